// File: rtl/data_mem_responder_if.sv
// Load/store request and response bus between an initiator (master) and data_mem_responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder; DMEM_MISALIGN_CHECK_EN enables the misaligned-access error.
// Latency: resp_valid rises LATENCY edges after the request, counting the accept edge as the first.
// Backpressure: req_ready only in IDLE; the response holds stable until resp_ready.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 3) ? 2 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  req_t             req_q;
  req_t             acc;
  logic             accept;
  logic             enter_resp;
  logic             acc_misalign;
  logic             mem_we;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             unused_addr_bits;
  logic [31:0]      mem [DEPTH];

  assign accept = bus.req_valid && (state == IDLE);

  // With LATENCY=1 RESP is entered on the accept edge, before req_q holds the request
  assign acc     = (state == IDLE) ? {bus.req_write, bus.req_addr, bus.req_wdata} : req_q;
  assign acc_idx = acc.addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_misalign = (acc.addr[1:0] != 2'b00);
`else
  assign acc_misalign = 1'b0;
`endif

  assign unused_addr_bits = ^{acc.addr[31:IDX_W+2], acc.addr[1:0]};

  assign mem_we = enter_resp && acc.write && !acc_misalign && !rst;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_nxt = CNT_W'(LATENCY);
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(2)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q <= {bus.req_write, bus.req_addr, bus.req_wdata};
      if (enter_resp) begin
        err_q   <= acc_misalign;
        rdata_q <= (acc.write || acc_misalign) ? 32'h0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc.wdata;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
- REQ-001: Parameter DEPTH, 64, number of 32-bit words; power of two, at least 2.
- REQ-002: Parameter LATENCY, 2, cycles from request accept edge to resp_valid rising; at least 1.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: req_valid  input  1  initiator presents a request.
- REQ-006: req_ready  output  1  responder can accept a request.
- REQ-007: req_write  input  1  1 = store, 0 = load.
- REQ-008: req_addr  input  32  byte address.
- REQ-009: req_wdata  input  32  store data.
- REQ-010: resp_valid  output  1  response available.
- REQ-011: resp_ready  input  1  initiator accepts the response.
- REQ-012: resp_rdata  output  32  load data; 0 for stores.
- REQ-013: resp_err  output  1  misaligned-access flag; see Configuration.

Function
- REQ-014: The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
- REQ-015: req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
- REQ-016: A request SHALL be accepted when req_valid=1 and req_ready=1 on a clk edge.
  - On accept, req_write, req_addr and req_wdata SHALL be latched.
  - On accept, a countdown SHALL load with LATENCY.
- REQ-017: On accept, the next state SHALL be RESP when LATENCY=1, otherwise WAIT.
- REQ-018: In WAIT, the counter SHALL decrement once per cycle.
  - The FSM SHALL go to RESP on the edge where the counter goes from 2 to 1.
  - resp_valid SHALL therefore rise exactly LATENCY edges after the accept edge.
- REQ-019: Memory access SHALL occur on the edge entering RESP.
  - Store: mem[idx] <= latched wdata; resp_rdata SHALL be 0.
  - Load: resp_rdata <= mem[idx].
- REQ-020: idx SHALL be req_addr[log2(DEPTH)+1:2].
  - Upper address bits SHALL be ignored, so addresses wrap modulo DEPTH words.
- REQ-021: In RESP, resp_rdata and resp_err SHALL stay stable until the handshake.
  - The handshake is resp_valid=1 and resp_ready=1 on a clk edge.
  - On the handshake, the next state SHALL be IDLE.
- REQ-022: Only one transaction SHALL be outstanding; no request is accepted in WAIT or RESP.
- REQ-023: A new request SHALL be accepted no earlier than the cycle after the response handshake.
- REQ-024: Changes on req_* after the accept edge SHALL NOT affect the transaction in flight.

Reset
- REQ-025: While rst=1, the FSM SHALL be in IDLE with counter=0, resp_valid=0, resp_rdata=0 and resp_err=0.
  - req_ready SHALL be 1 while rst=1.
- REQ-026: Memory contents SHALL NOT be reset.
- REQ-027: Asserting rst in WAIT or RESP SHALL abandon the transaction.
  - A store not yet committed SHALL be dropped.
  - No response SHALL be produced for an abandoned transaction.

Configuration
- REQ-028: Macro DMEM_MISALIGN_CHECK_EN, when defined, SHALL enable the misalignment check.
  - A request with latched addr[1:0]!=0 performs no memory access.
  - Its response SHALL have resp_err=1 and resp_rdata=0, with the same LATENCY and handshake.
- REQ-029: When DMEM_MISALIGN_CHECK_EN is undefined, resp_err SHALL be tied 0 and addr[1:0] SHALL be ignored.

Verification (DEPTH=64, LATENCY=2)
- REQ-030: Release reset, store 0xDEADBEEF to 0x10, then load 0x10.
  - Load response: resp_rdata=0xDEADBEEF, resp_err=0.
  - Each resp_valid rises 2 edges after its accept.
- REQ-031: Load with resp_ready=0 for 3 cycles in RESP.
  - resp_valid=1, resp_rdata stable and req_ready=0 throughout.
  - IDLE on the edge where resp_ready=1.
- REQ-032: Store 0x11111111 to 0x100, then load 0x0.
  - resp_rdata=0x11111111 (wrap to index 0).
- REQ-033: Store to 0x13.
  - With macro: resp_err=1, resp_rdata=0, and a load from 0x10 returns its prior value.
  - Without macro: the store writes word 4, resp_err=0.
- REQ-034: Preload 0xA5A5A5A5 at 0x20, store 0x5A5A5A5A to 0x20, assert rst in WAIT.
  - resp_valid=0 and req_ready=1 after reset.
  - A subsequent load of 0x20 returns 0xA5A5A5A5.
